// File: rtl/key_repeat_ctrl.sv
// N-channel push-button front end: synchroniser, debouncer, press/release pulses
// and hold-to-auto-repeat event generator, one independent pipeline per key.
module key_repeat_ctrl #(
  parameter int N_KEYS       = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int DEBOUNCE_CYC = 250000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [N_KEYS-1:0] iKEY,
  input  logic [N_KEYS-1:0] iREPEAT_EN,
  output logic [N_KEYS-1:0] oLEVEL,
  output logic [N_KEYS-1:0] oPRESS,
  output logic [N_KEYS-1:0] oRELEASE,
  output logic [N_KEYS-1:0] oEVENT,
  output logic              oANY
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam int T_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW    = $clog2(T_MAX);

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [TW-1:0]   DLY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0]   RATE_LAST = TW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  // Everything past this point is active-high: 1 = pressed.
  logic [N_KEYS-1:0] key_norm;
  assign key_norm = (ACTIVE_LOW != 0) ? ~iKEY : iKEY;

  genvar gi;
  generate
    for (gi = 0; gi < N_KEYS; gi++) begin : g_key
      logic            s1_reg;
      logic            s2_reg;
      logic            level_reg;
      logic            press_reg;
      logic            release_reg;
      logic            event_reg;
      logic [DB_W-1:0] db_cnt_reg;
      logic            accept;
      logic            press_next;
      logic            release_next;
      state_t          state_reg;
      state_t          state_next;
      logic [TW-1:0]   timer_reg;
      logic [TW-1:0]   timer_next;
      logic            event_next;

      assign accept       = (s2_reg != level_reg) && (db_cnt_reg == DB_LAST);
      assign press_next   = accept && s2_reg;
      assign release_next = accept && !s2_reg;

      always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
          s1_reg      <= 1'b0;
          s2_reg      <= 1'b0;
          level_reg   <= 1'b0;
          db_cnt_reg  <= '0;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
        end else begin
          s1_reg <= key_norm[gi];
          s2_reg <= s1_reg;
          // Any return to the stable level restarts the count.
          if (s2_reg == level_reg) begin
            db_cnt_reg <= '0;
          end else if (accept) begin
            level_reg  <= s2_reg;
            db_cnt_reg <= '0;
          end else begin
            db_cnt_reg <= db_cnt_reg + DB_W'(1);
          end
          press_reg   <= press_next;
          release_reg <= release_next;
        end
      end

      always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
          state_reg <= IDLE;
          timer_reg <= '0;
          event_reg <= 1'b0;
        end else begin
          state_reg <= state_next;
          timer_reg <= timer_next;
          event_reg <= event_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        event_next = 1'b0;
        // A release wins over a repeat that would fire in the same cycle.
        if (release_next) begin
          state_next = IDLE;
          timer_next = '0;
        end else begin
          case (state_reg)
            IDLE: begin
              if (press_next) begin
                event_next = 1'b1;
                state_next = DELAY;
                timer_next = '0;
              end
            end
            DELAY: begin
              if (!iREPEAT_EN[gi]) begin
                timer_next = '0;
              end else if (timer_reg == DLY_LAST) begin
                event_next = 1'b1;
                state_next = REPEAT;
                timer_next = '0;
              end else begin
                timer_next = timer_reg + TW'(1);
              end
            end
            REPEAT: begin
              if (!iREPEAT_EN[gi]) begin
                state_next = DELAY;
                timer_next = '0;
              end else if (timer_reg == RATE_LAST) begin
                event_next = 1'b1;
                timer_next = '0;
              end else begin
                timer_next = timer_reg + TW'(1);
              end
            end
            default: begin
              state_next = IDLE;
              timer_next = '0;
            end
          endcase
        end
      end

      assign oLEVEL[gi]   = level_reg;
      assign oPRESS[gi]   = press_reg;
      assign oRELEASE[gi] = release_reg;
      assign oEVENT[gi]   = event_reg;
    end
  endgenerate

  assign oANY = |oLEVEL;

endmodule

// File: tb/tb_key_repeat_ctrl.sv
// Bench for key_repeat_ctrl: fixed vector table, directed multi-cycle sequences
// and randomized key activity, all against a behavioural model of the key rules.
module tb_key_repeat_ctrl;

  localparam int N   = 4;
  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RR  = 3;

  logic         iCLK = 1'b0;
  logic         iRST;
  logic [N-1:0] iKEY;
  logic [N-1:0] iREPEAT_EN;
  logic [N-1:0] oLEVEL;
  logic [N-1:0] oPRESS;
  logic [N-1:0] oRELEASE;
  logic [N-1:0] oEVENT;
  logic         oANY;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  key_repeat_ctrl #(
    .N_KEYS(N), .ACTIVE_LOW(1), .DEBOUNCE_CYC(DEB),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iKEY(iKEY), .iREPEAT_EN(iREPEAT_EN),
    .oLEVEL(oLEVEL), .oPRESS(oPRESS), .oRELEASE(oRELEASE),
    .oEVENT(oEVENT), .oANY(oANY)
  );

  always #5 iCLK = ~iCLK;

  // Reference model: a two-sample delay line, a "how long has the sampled value
  // disagreed with the level" run length, and a hold age counted in enabled cycles.
  logic [N-1:0] m_s1, m_s2, m_lvl, m_prs, m_rel, m_evt;
  int           m_diff[N];
  int           m_age[N];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prs = '0; m_rel = '0; m_evt = '0;
    for (int k = 0; k < N; k++) begin
      m_diff[k] = 0;
      m_age[k]  = 0;
    end
  endtask

  task automatic model_edge();
    if (iRST) begin
      model_reset();
      return;
    end
    for (int k = 0; k < N; k++) begin
      logic smp;
      smp = m_s2[k];
      m_prs[k] = 1'b0; m_rel[k] = 1'b0; m_evt[k] = 1'b0;
      if (smp != m_lvl[k]) begin
        m_diff[k] = m_diff[k] + 1;
        if (m_diff[k] == DEB) begin
          m_lvl[k]  = smp;
          m_diff[k] = 0;
          if (smp) m_prs[k] = 1'b1;
          else     m_rel[k] = 1'b1;
        end
      end else begin
        m_diff[k] = 0;
      end
      if (m_prs[k]) begin
        m_evt[k] = 1'b1;
        m_age[k] = 0;
      end else if (m_lvl[k]) begin
        if (iREPEAT_EN[k]) begin
          m_age[k] = m_age[k] + 1;
          if (m_age[k] >= RD && ((m_age[k] - RD) % RR) == 0) m_evt[k] = 1'b1;
        end else begin
          m_age[k] = 0;
        end
      end
      m_s2[k] = m_s1[k];
      m_s1[k] = ~iKEY[k];
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({oLEVEL, oPRESS, oRELEASE, oEVENT, oANY});
  endfunction

  task automatic step();
    model_edge();
    @(posedge iCLK);
    #1;
    cyc++;
    check("model", outs(), 32'({m_lvl, m_prs, m_rel, m_evt, |m_lvl}));
  endtask

  // Hold key k and record oEVENT[k] over offsets 0..31 from the press pulse.
  // mode 0: repeat enabled, 1: disabled, 2: enable dropped at P+12, restored at P+15.
  task automatic run_hold(input int k, input int mode, input logic [31:0] exp_mask,
                          input string name);
    logic [31:0] mask;
    int          lat;
    mask = '0;
    lat  = 0;
    iKEY[k]       = 1'b0;
    iREPEAT_EN[k] = (mode != 1);
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      step();
      if (oPRESS[k]) lat = i;
    end
    check({name, "_press_lat"}, lat, 6);
    mask[0] = oEVENT[k];
    for (int o = 1; o < 32; o++) begin
      step();
      mask[o] = oEVENT[k];
      if (mode == 2 && o == 12) iREPEAT_EN[k] = 1'b0;
      if (mode == 2 && o == 15) iREPEAT_EN[k] = 1'b1;
    end
    check({name, "_events"}, mask, exp_mask);
    $display("[TB] %s key=%0d press_lat=%0d events=%h", name, k, lat, mask);
  endtask

  task automatic release_key(input int k, input string name);
    int   lat;
    logic ev;
    lat = 0;
    ev  = 1'b0;
    iKEY[k] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (oRELEASE[k] && lat == 0) begin
        lat = i;
        ev  = oEVENT[k];
      end
    end
    check({name, "_rel_lat"}, lat, 6);
    check({name, "_rel_noevent"}, 32'(ev), 0);
    check({name, "_rel_level"}, 32'(oLEVEL[k]), 0);
    $display("[TB] %s key=%0d release_lat=%0d", name, k, lat);
  endtask

  typedef struct {
    logic [N-1:0] key;
    logic [N-1:0] en;
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
    logic [N-1:0] evt;
    logic         anyk;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int act;
    int presses;
    int at;
    int lat;
    logic [31:0] mask;

    // Clean press then release on key 0; level rises on the 6th edge.
    tbl[0]  = '{4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[1]  = '{4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[2]  = '{4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[3]  = '{4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[4]  = '{4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[5]  = '{4'hE, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 1'b1};
    tbl[6]  = '{4'hE, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1};
    tbl[7]  = '{4'hE, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1};
    tbl[8]  = '{4'hF, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1};
    tbl[9]  = '{4'hF, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1};
    tbl[10] = '{4'hF, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1};
    tbl[11] = '{4'hF, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1};
    tbl[12] = '{4'hF, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1};
    tbl[13] = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 1'b0};
    tbl[14] = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};

    iRST = 1'b1; iKEY = 4'hF; iREPEAT_EN = 4'h0;
    model_reset();
    #12;
    check("reset_outputs", outs(), 0);
    step();
    step();
    iRST = 1'b0;

    for (int i = 0; i < 15; i++) begin
      iKEY       = tbl[i].key;
      iREPEAT_EN = tbl[i].en;
      step();
      check("vec", outs(), 32'({tbl[i].lvl, tbl[i].prs, tbl[i].rel, tbl[i].evt, tbl[i].anyk}));
      $display("[TB] vec %0d key=%h lvl=%h prs=%h rel=%h evt=%h any=%b",
               i, iKEY, oLEVEL, oPRESS, oRELEASE, oEVENT, oANY);
    end

    // Bounce on key 1: 2-cycle runs never reach the debounce count.
    act = 0;
    for (int i = 0; i < 12; i++) begin
      iKEY[1] = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      step();
      if (oLEVEL[1] || oPRESS[1] || oEVENT[1]) act++;
    end
    check("bounce_quiet", act, 0);
    iKEY[1] = 1'b0;
    presses = 0;
    at = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (oPRESS[1]) begin
        presses++;
        at = i;
      end
    end
    check("bounce_presses", presses, 1);
    check("bounce_lat", at, 6);
    $display("[TB] bounce key=1 presses=%0d lat=%0d", presses, at);
    release_key(1, "bounce");

    // Auto-repeat on key 2; the mode-0 release coincides with a repeat at P+37.
    run_hold(2, 0, 32'h9249_2401, "repeat_on");
    release_key(2, "repeat_on");
    run_hold(2, 1, 32'h0000_0001, "repeat_off");
    release_key(2, "repeat_off");
    run_hold(2, 2, 32'h9200_0401, "repeat_gap");
    release_key(2, "repeat_gap");

    // Simultaneous press of keys 2 and 3.
    iKEY[3:2] = 2'b00;
    iREPEAT_EN[3:2] = 2'b11;
    lat = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      step();
      if (oPRESS != 4'h0) lat = i;
    end
    check("simul_press", 32'(oPRESS), 32'h0000_000C);
    check("simul_event0", 32'(oEVENT), 32'h0000_000C);
    for (int i = 0; i < 10; i++) step();
    check("simul_event10", 32'(oEVENT), 32'h0000_000C);
    for (int i = 0; i < 3; i++) step();
    check("simul_event13", 32'(oEVENT), 32'h0000_000C);
    $display("[TB] simul keys=3,2 lat=%0d", lat);
    iKEY[3:2] = 2'b11;
    for (int i = 0; i < 8; i++) step();
    check("simul_released", 32'(oLEVEL), 0);

    // Reset mid-hold on key 0.
    iKEY[0] = 1'b0;
    iREPEAT_EN[0] = 1'b1;
    lat = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      step();
      if (oPRESS[0]) lat = i;
    end
    for (int i = 0; i < 12; i++) step();
    #2;
    iRST = 1'b1;
    model_reset();
    #1;
    check("async_reset", outs(), 0);
    step();
    step();
    iRST = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      step();
      if (oPRESS[0]) lat = i;
    end
    check("rst_repress_lat", lat, 6);
    mask = '0;
    mask[0] = oEVENT[0];
    for (int o = 1; o < 14; o++) begin
      step();
      mask[o] = oEVENT[0];
    end
    check("rst_repress_events", mask, 32'h0000_2401);
    $display("[TB] reset_mid_hold lat=%0d events=%h", lat, mask);
    iKEY[0] = 1'b1;
    for (int i = 0; i < 8; i++) step();

    // Random key and enable activity against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 15) == 0) iKEY[k] = ~iKEY[k];
        if ($urandom_range(0, 59) == 0) iREPEAT_EN[k] = ~iREPEAT_EN[k];
      end
      step();
      if (c % 500 == 499)
        $display("[TB] random cycle %0d lvl=%h en=%h", c + 1, oLEVEL, iREPEAT_EN);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_repeat_ctrl.md
Name: key_repeat_ctrl

Overview:
- Parametrised N-channel front end for the push-button inputs (up/left/down/right today, more keys later) ahead of the tetris control logic.
- Per key, in order:
  - 2-flop synchroniser.
  - Counter-based debouncer.
  - Press/release edge pulses.
  - Optional hold-to-auto-repeat event generator (initial delay, then fixed rate).
- Replaces raw button wiring into game logic; one instance per clock domain, normally iVGA_CLK or CLOCK_50.

Parameters:
- N_KEYS, 4, number of independent key channels.
- ACTIVE_LOW, 1, 1 means raw iKEY is 0 when pressed (DE2 KEY convention); 0 means active-high.
- DEBOUNCE_CYC, 250000, consecutive stable cycles required to accept a new level (>=1).
- REPEAT_DELAY, 25000000, cycles from accepted press to first repeat event (>=2).
- REPEAT_RATE, 5000000, cycles between subsequent repeat events (>=2).

Ports:
- iCLK  in  1  sole clock; all state on rising edge.
- iRST  in  1  asynchronous, active-high reset.
- iKEY  in  N_KEYS  raw asynchronous key inputs, polarity per ACTIVE_LOW.
- iREPEAT_EN  in  N_KEYS  per-key auto-repeat enable (synchronous to iCLK).
- oLEVEL  out  N_KEYS  debounced level, 1 = pressed.
- oPRESS  out  N_KEYS  1-cycle pulse on accepted press.
- oRELEASE  out  N_KEYS  1-cycle pulse on accepted release.
- oEVENT  out  N_KEYS  1-cycle pulse per action: the press itself plus each repeat.
- oANY  out  1  OR of oLEVEL.

Behaviour:
- Reset (async assert, sync-safe deassert is the caller's job):
  - All outputs 0.
  - Synchroniser flops and stable state reset to the "released" value, so sync resets to ~ACTIVE_LOW-adjusted released level.
  - All counters 0; all FSMs IDLE.
- Normalisation: k = ACTIVE_LOW ? ~iKEY : iKEY; everything downstream is active-high.
- Synchroniser: s1 <= k; s2 <= s1. Two-cycle latency.
- Debounce, per key:
  - Counter db_cnt, width $clog2(DEBOUNCE_CYC+1).
  - If s2 == oLEVEL: db_cnt <= 0.
  - Else if db_cnt == DEBOUNCE_CYC-1: oLEVEL <= s2, db_cnt <= 0.
  - Else db_cnt++.
  - Any glitch back to the stable level restarts the count.
- Latency: clean raw change → oLEVEL updates after the (2+DEBOUNCE_CYC)th rising edge.
- oPRESS/oRELEASE: registered, high exactly during the first cycle oLEVEL shows its new value.
- Repeat FSM, per key; states IDLE, DELAY, REPEAT; timer width $clog2(max(REPEAT_DELAY,REPEAT_RATE)).
  - IDLE: on accepted press, oEVENT pulses the same cycle as oPRESS → DELAY, timer 0.
  - DELAY: with iREPEAT_EN=1, timer++. When timer == REPEAT_DELAY-1: next cycle oEVENT pulse → REPEAT, timer 0. The first repeat is exactly REPEAT_DELAY cycles after the press pulse.
  - REPEAT: timer++. When timer == REPEAT_RATE-1: oEVENT pulse, timer 0, giving events every REPEAT_RATE cycles.
  - iREPEAT_EN=0 while in DELAY or REPEAT: timer cleared, state forced to DELAY, no events. Re-enabling restarts the full delay.
  - Accepted release in any state → IDLE, timer 0. No oEVENT on release. A release in the same cycle a repeat would fire suppresses the repeat.
- Channels are fully independent; any combination of pulses in the same cycle is legal.
- oANY is combinational OR of registered oLEVEL.
- Reset mid-hold with key still held after deassert: stable level is "released", so a fresh press is accepted 2+DEBOUNCE_CYC cycles after deassert, with oPRESS and oEVENT.
- Width rule: counters never wrap; compares are equality at terminal count.

Test Plan:
Bench params: N_KEYS=4, ACTIVE_LOW=1, DEBOUNCE_CYC=4, REPEAT_DELAY=10, REPEAT_RATE=3.
1. Clean press: iKEY[0] 1→0 before edge 0, held → oLEVEL[0]=1 after edge 6; oPRESS[0] and oEVENT[0] high only in that cycle (P); other keys 0; oANY=1.
2. Bounce: iKEY[1] toggles every 2 cycles for 12 cycles, then settles 0 → no output activity during bounce; oLEVEL[1] rises 6 edges after final settle; exactly one oPRESS[1].
3. Auto-repeat: key2 held with iREPEAT_EN[2]=1 → oEVENT[2] at P, P+10, P+13, P+16, P+19. Repeat with iREPEAT_EN[2]=0 → only at P. Drop enable at P+12 and restore at P+15 → next event at P+25.
4. Release: key0 raw 0→1 at P+11 → oRELEASE[0] 6 edges later, oLEVEL[0]=0, no oEVENT. Re-press → oEVENT at P' then P'+10 (delay restarted).
5. Simultaneous: keys 2 and 3 pressed same cycle → oPRESS=4'b1100 in one cycle; repeats coincide at P+10, P+13.
6. Reset mid-hold: assert iRST at P+12 with key0 held → all outputs 0 immediately (no clock needed). Deassert with key still held → oPRESS[0] and oEVENT[0] pulse 6 edges after deassert; repeat resumes at +10.
